// File: rtl/fib_pkg_amisha.sv
// rtl/fib_pkg_amisha.sv - shared state encoding, mode codes and seed constants
// Purpose: types and constants used by the Fibonacci/Lucas sequence generator.
// Ports: none (package).
package fib_pkg_amisha;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } fib_state_t;

  localparam logic [1:0] MODE_FIB    = 2'b00;
  localparam logic [1:0] MODE_LUCAS  = 2'b01;
  localparam logic [1:0] MODE_CUSTOM = 2'b10;

  localparam int unsigned FIB_SEED0 = 0;
  localparam int unsigned FIB_SEED1 = 1;
  localparam int unsigned LUC_SEED0 = 2;
  localparam int unsigned LUC_SEED1 = 1;

endpackage

// File: rtl/fib_add_amisha.sv
// rtl/fib_add_amisha.sv - W-bit adder with carry out and optional saturation
// Purpose: produces a+b for the sequence datapath; with SATURATE=1 a carry clamps
//   the sum to all-ones.
// Ports: a_amisha/b_amisha (W) operands; sum_amisha (W) result; carry_amisha (1)
//   carry out of the unclamped addition.
module fib_add_amisha #(
  parameter int W        = 20,
  parameter int SATURATE = 0
) (
  input  logic [W-1:0] a_amisha,
  input  logic [W-1:0] b_amisha,
  output logic [W-1:0] sum_amisha,
  output logic         carry_amisha
);

  logic [W-1:0] raw_sum;

  assign {carry_amisha, raw_sum} = {1'b0, a_amisha} + {1'b0, b_amisha};
  assign sum_amisha = ((SATURATE != 0) && carry_amisha) ? {W{1'b1}} : raw_sum;

endmodule

// File: rtl/fib_gen_param_amisha.sv
// rtl/fib_gen_param_amisha.sv - start/done coprocessor computing term i of s(k)=s(k-1)+s(k-2)
// Purpose: iterative two-seed additive sequence generator (Fibonacci, Lucas, custom)
//   with sticky overflow, optional saturation and abort.
// Ports: clk_amisha, reset_n_amisha (sync active-low); start_amisha, abort_amisha;
//   mode_amisha (2); i_amisha (NW); seed0_amisha/seed1_amisha (W);
//   ready_amisha, done_tick_amisha, ovf_amisha, f_amisha (W).
module fib_gen_param_amisha
  import fib_pkg_amisha::*;
#(
  parameter int W        = 20,
  parameter int NW       = 5,
  parameter int SATURATE = 0
) (
  input  logic          clk_amisha,
  input  logic          reset_n_amisha,
  input  logic          start_amisha,
  input  logic          abort_amisha,
  input  logic [1:0]    mode_amisha,
  input  logic [NW-1:0] i_amisha,
  input  logic [W-1:0]  seed0_amisha,
  input  logic [W-1:0]  seed1_amisha,
  output logic          ready_amisha,
  output logic          done_tick_amisha,
  output logic          ovf_amisha,
  output logic [W-1:0]  f_amisha
);

  fib_state_t    state_q, state_d;
  logic [W-1:0]  t0_q, t0_d;
  logic [W-1:0]  t1_q, t1_d;
  logic [NW-1:0] n_q, n_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  s0_sel, s1_sel;
  logic [W-1:0]  sum;
  logic          carry;

  fib_add_amisha #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_add (
    .a_amisha     (t1_q),
    .b_amisha     (t0_q),
    .sum_amisha   (sum),
    .carry_amisha (carry)
  );

  // Seed selection; mode 11 falls back to Fibonacci.
  always_comb begin
    s0_sel = W'(FIB_SEED0);
    s1_sel = W'(FIB_SEED1);
    case (mode_amisha)
      MODE_LUCAS: begin
        s0_sel = W'(LUC_SEED0);
        s1_sel = W'(LUC_SEED1);
      end
      MODE_CUSTOM: begin
        s0_sel = seed0_amisha;
        s1_sel = seed1_amisha;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    t0_d             = t0_q;
    t1_d             = t1_q;
    n_d              = n_q;
    ovf_d            = ovf_q;
    ready_amisha     = 1'b0;
    done_tick_amisha = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_amisha = 1'b1;
        // Seeds and index are latched here, so later input changes cannot
        // disturb the run.
        if (start_amisha) begin
          t0_d    = s0_sel;
          t1_d    = s1_sel;
          n_d     = i_amisha;
          ovf_d   = 1'b0;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (abort_amisha) begin
          state_d = ST_IDLE;
        end else if (n_q == '0) begin
          t1_d    = t0_q;
          state_d = ST_DONE;
        end else if (n_q == NW'(1)) begin
          state_d = ST_DONE;
        end else begin
          // Invariant: t1 holds s(i-n+1), t0 holds s(i-n).
          t1_d = sum;
          t0_d = t1_q;
          n_d  = n_q - NW'(1);
          if (carry) begin
            ovf_d = 1'b1;
            // Sum is already clamped by the adder; finish early.
            if (SATURATE != 0) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_tick_amisha = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (!reset_n_amisha) begin
      state_q <= ST_IDLE;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      ovf_q   <= ovf_d;
    end
  end

  assign f_amisha   = t1_q;
  assign ovf_amisha = ovf_q;

endmodule

// File: tb/tb_fib_gen_param_amisha.sv
// tb/tb_fib_gen_param_amisha.sv - directed self-checking bench for fib_gen_param_amisha
module tb_fib_gen_param_amisha;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  idx = 5'd0;
  logic [19:0] seed0 = 20'd0;
  logic [19:0] seed1 = 20'd0;

  logic        ready, done, ovf;
  logic [19:0] f;
  logic        ready_s, done_s, ovf_s;
  logic [19:0] f_s;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fib_gen_param_amisha #(.W(20), .NW(5), .SATURATE(0)) dut (
    .clk_amisha       (clk),
    .reset_n_amisha   (reset_n),
    .start_amisha     (start),
    .abort_amisha     (abort),
    .mode_amisha      (mode),
    .i_amisha         (idx),
    .seed0_amisha     (seed0),
    .seed1_amisha     (seed1),
    .ready_amisha     (ready),
    .done_tick_amisha (done),
    .ovf_amisha       (ovf),
    .f_amisha         (f)
  );

  fib_gen_param_amisha #(.W(20), .NW(5), .SATURATE(1)) dut_sat (
    .clk_amisha       (clk),
    .reset_n_amisha   (reset_n),
    .start_amisha     (start),
    .abort_amisha     (abort),
    .mode_amisha      (mode),
    .i_amisha         (idx),
    .seed0_amisha     (seed0),
    .seed1_amisha     (seed1),
    .ready_amisha     (ready_s),
    .done_tick_amisha (done_s),
    .ovf_amisha       (ovf_s),
    .f_amisha         (f_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and waits for done on the chosen instance; returns the number of
  // edges after the accepting edge until done_tick was seen.
  task automatic run(input logic [1:0] m, input logic [4:0] i, input logic [19:0] a,
                     input logic [19:0] b, input bit sat, input bit scramble,
                     output int lat);
    mode = m; idx = i; seed0 = a; seed1 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      mode = 2'b01; idx = 5'd17; seed0 = 20'd99; seed1 = 20'd1234;
    end
    lat = 0;
    while (!(sat ? done_s : done) && lat < 200) begin
      tick();
      lat++;
    end
    if (lat >= 200) chk("timeout", 32'(lat), 32'd0);
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  int lat;
  int seen_done;

  initial begin
    tick();
    tick();
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: Fibonacci i=10
    run(2'b00, 5'd10, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("fib10_lat", 32'(lat), 32'd10);
    chk("fib10_f", 32'(f), 32'd55);
    chk("fib10_ovf", 32'(ovf), 32'd0);
    tick();
    chk("fib10_done_once", 32'(done), 32'd0);
    chk("fib10_ready", 32'(ready), 32'd1);

    // 2: Lucas and small indices; back-to-back starts
    run(2'b01, 5'd5, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("luc5_f", 32'(f), 32'd11);
    tick();
    run(2'b01, 5'd0, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("luc0_lat", 32'(lat), 32'd1);
    chk("luc0_f", 32'(f), 32'd2);
    tick();
    run(2'b00, 5'd1, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("fib1_lat", 32'(lat), 32'd1);
    chk("fib1_f", 32'(f), 32'd1);
    tick();
    run(2'b11, 5'd7, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("mode11_f", 32'(f), 32'd13);
    settle();

    // 3: custom seeds, then seeds changed after acceptance
    run(2'b10, 5'd3, 20'd3, 20'd4, 1'b0, 1'b0, lat);
    chk("cust_f", 32'(f), 32'd11);
    settle();
    run(2'b10, 5'd3, 20'd3, 20'd4, 1'b0, 1'b1, lat);
    chk("cust_scr_f", 32'(f), 32'd11);
    chk("cust_scr_lat", 32'(lat), 32'd3);
    settle();

    // 4: overflow without and with saturation
    run(2'b00, 5'd31, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("fib31_lat", 32'(lat), 32'd31);
    chk("fib31_f", 32'(f), 32'd297693);
    chk("fib31_ovf", 32'(ovf), 32'd1);
    settle();
    run(2'b00, 5'd30, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("fib30_f", 32'(f), 32'd832040);
    chk("fib30_ovf", 32'(ovf), 32'd0);
    settle();
    run(2'b00, 5'd31, 20'd0, 20'd0, 1'b1, 1'b0, lat);
    chk("sat31_lat", 32'(lat), 32'd30);
    chk("sat31_f", 32'(f_s), 32'hFFFFF);
    chk("sat31_ovf", 32'(ovf_s), 32'd1);
    settle();
    settle();

    // 5: abort in the third OP cycle
    mode = 2'b00; idx = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    seen_done = 0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 25; k++) begin
      if (done) seen_done++;
      tick();
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);

    // start while busy is ignored
    mode = 2'b00; idx = 5'd4; start = 1'b1;
    tick();
    idx = 5'd9; mode = 2'b01;
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    start = 1'b0;
    chk("busy_lat", 32'(lat), 32'd4);
    chk("busy_f", 32'(f), 32'd3);
    tick();
    tick();
    settle();

    // start+abort together in IDLE: start wins
    mode = 2'b00; idx = 5'd6; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("stab_busy", 32'(ready), 32'd0);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("stab_lat", 32'(lat), 32'd6);
    chk("stab_f", 32'(f), 32'd8);
    settle();

    // 6: reset mid-run, then an async low pulse between edges
    run(2'b00, 5'd31, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    settle();
    idx = 5'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mrst_ready", 32'(ready), 32'd1);
    chk("mrst_f", 32'(f), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    run(2'b01, 5'd4, 20'd0, 20'd0, 1'b0, 1'b0, lat);
    chk("pre_pulse_f", 32'(f), 32'd7);
    settle();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    chk("pulse_f", 32'(f), 32'd7);
    chk("pulse_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
